// File: rtl/base2log.sv
// Pipelined unsigned log2: leading-one detect plus normalised fraction, one output register.
// Define BASE2LOG_FRAC_LUT_EN to use a rounded lookup fraction instead of Mitchell truncation.
module base2log #(
    parameter int unsigned FRAC_BITS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [31:0] number_i,
    output logic        valid_o,
    output logic [7:0]  log_o,
    output logic        zero_o
);

    // Keep only the top FRAC_BITS fractional bits, zeroing the rest.
    localparam logic [2:0] FRAC_MASK = (FRAC_BITS >= 3) ? 3'b111 :
                                       (FRAC_BITS == 2) ? 3'b110 : 3'b100;

    logic [4:0]  msb_pos;
    logic [31:0] norm;
    logic [2:0]  f3;
    logic [7:0]  log_next;
    logic        zero_next;

    always_comb begin
        msb_pos = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (number_i[i]) msb_pos = 5'(i);
        end
    end

    // Shift the leading one to bit 31 so the mantissa sits left-aligned in bits [30:0].
    assign norm = number_i << (5'd31 - msb_pos);

`ifdef BASE2LOG_FRAC_LUT_EN
    logic [3:0] m4;
    assign m4 = 4'(norm >> 27);

    always_comb begin
        case (m4)
            4'd0:    f3 = 3'd0;
            4'd1:    f3 = 3'd1;
            4'd2:    f3 = 3'd1;
            4'd3:    f3 = 3'd2;
            4'd4:    f3 = 3'd3;
            4'd5:    f3 = 3'd3;
            4'd6:    f3 = 3'd4;
            4'd7:    f3 = 3'd4;
            4'd8:    f3 = 3'd5;
            4'd9:    f3 = 3'd5;
            4'd10:   f3 = 3'd6;
            4'd11:   f3 = 3'd6;
            4'd12:   f3 = 3'd6;
            default: f3 = 3'd7;
        endcase
    end
`else
    assign f3 = 3'(norm >> 28);
`endif

    assign zero_next = (number_i == '0);
    assign log_next  = zero_next ? '0 : {msb_pos, f3 & FRAC_MASK};

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o <= 1'b0;
            log_o   <= '0;
            zero_o  <= 1'b0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                log_o  <= log_next;
                zero_o <= zero_next;
            end
        end
    end

endmodule

// File: tb/tb_base2log.sv
// Directed vector bench for base2log; expectations follow BASE2LOG_FRAC_LUT_EN when defined.
module tb_base2log;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic [31:0] number_i;
    logic        valid_o;
    logic [7:0]  log_o;
    logic        zero_o;
    logic        valid_o_f1;
    logic [7:0]  log_o_f1;
    logic        zero_o_f1;

    int n_cmp = 0;
    int n_err = 0;

`ifdef BASE2LOG_FRAC_LUT_EN
    localparam bit LUT = 1'b1;
`else
    localparam bit LUT = 1'b0;
`endif

    base2log #(.FRAC_BITS(3)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .number_i(number_i),
        .valid_o(valid_o), .log_o(log_o), .zero_o(zero_o)
    );

    base2log #(.FRAC_BITS(1)) dut_f1 (
        .clk(clk), .rst(rst), .valid_i(valid_i), .number_i(number_i),
        .valid_o(valid_o_f1), .log_o(log_o_f1), .zero_o(zero_o_f1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] num;
        logic [7:0]  log_mitchell;
        logic [7:0]  log_lut;
        logic        zero;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{"zero",      32'h0000_0000, 8'h00, 8'h00, 1'b1};
        vecs[1]  = '{"one",       32'h0000_0001, 8'h00, 8'h00, 1'b0};
        vecs[2]  = '{"msb_only",  32'h8000_0000, 8'hF8, 8'hF8, 1'b0};
        vecs[3]  = '{"all_ones",  32'hFFFF_FFFF, 8'hFF, 8'hFF, 1'b0};
        vecs[4]  = '{"twelve",    32'd12,        8'h1C, 8'h1D, 1'b0};
        vecs[5]  = '{"five",      32'd5,         8'h12, 8'h13, 1'b0};
        vecs[6]  = '{"two",       32'd2,         8'h08, 8'h08, 1'b0};
        vecs[7]  = '{"three",     32'd3,         8'h0C, 8'h0D, 1'b0};
        vecs[8]  = '{"zero_mid",  32'd0,         8'h00, 8'h00, 1'b1};
        vecs[9]  = '{"k1024",     32'd1024,      8'h50, 8'h50, 1'b0};
        vecs[10] = '{"seven",     32'd7,         8'h16, 8'h16, 1'b0};
        vecs[11] = '{"six",       32'd6,         8'h14, 8'h15, 1'b0};
        vecs[12] = '{"x300",      32'h0000_0300, 8'h4C, 8'h4D, 1'b0};
        vecs[13] = '{"x255",      32'd255,       8'h3F, 8'h3F, 1'b0};
        vecs[14] = '{"nine",      32'd9,         8'h19, 8'h19, 1'b0};
        vecs[15] = '{"ten",       32'd10,        8'h1A, 8'h1B, 1'b0};

        rst = 1'b1;
        valid_i = 1'b0;
        number_i = '0;
        tick();
        tick();
        check("reset_valid", 32'(valid_o), 32'd0);
        check("reset_log",   32'(log_o),   32'd0);
        check("reset_zero",  32'(zero_o),  32'd0);

        rst = 1'b0;
        tick();
        check("idle_valid", 32'(valid_o), 32'd0);

        // Back-to-back stream: each operand's result appears one edge later.
        for (int i = 0; i < 16; i++) begin
            valid_i  = 1'b1;
            number_i = vecs[i].num;
            tick();
            check({vecs[i].name, "_valid"}, 32'(valid_o), 32'd1);
            check({vecs[i].name, "_log"},   32'(log_o),   32'(LUT ? vecs[i].log_lut : vecs[i].log_mitchell));
            check({vecs[i].name, "_zero"},  32'(zero_o),  32'(vecs[i].zero));
        end

        // Zero result held through idle cycles.
        valid_i  = 1'b1;
        number_i = 32'd0;
        tick();
        valid_i  = 1'b0;
        number_i = 32'hFFFF_FFFF;
        tick();
        check("hold_valid", 32'(valid_o), 32'd0);
        check("hold_log",   32'(log_o),   32'd0);
        check("hold_zero",  32'(zero_o),  32'd1);
        tick();
        check("hold2_zero", 32'(zero_o),  32'd1);

        // Non-zero result held through idle.
        valid_i  = 1'b1;
        number_i = 32'd1024;
        tick();
        valid_i  = 1'b0;
        number_i = 32'd3;
        tick();
        check("hold_nz_valid", 32'(valid_o), 32'd0);
        check("hold_nz_log",   32'(log_o),   32'h50);
        check("hold_nz_zero",  32'(zero_o),  32'd0);

        // FRAC_BITS=1 instance drops the low fractional bits.
        valid_i  = 1'b1;
        number_i = 32'd7;
        tick();
        check("f1_seven_valid", 32'(valid_o_f1), 32'd1);
        check("f1_seven_log",   32'(log_o_f1),   32'h14);
        number_i = 32'hFFFF_FFFF;
        tick();
        check("f1_ones_log",    32'(log_o_f1),   32'hFC);
        check("f1_ones_zero",   32'(zero_o_f1),  32'd0);

        // Reset wins over a simultaneous operand, then the first operand after release flows normally.
        valid_i  = 1'b1;
        number_i = 32'h0000_FFFF;
        rst      = 1'b1;
        tick();
        check("rst_pri_valid", 32'(valid_o), 32'd0);
        check("rst_pri_log",   32'(log_o),   32'd0);
        check("rst_pri_zero",  32'(zero_o),  32'd0);
        rst      = 1'b0;
        number_i = 32'h10;
        tick();
        check("post_rst_valid", 32'(valid_o), 32'd1);
        check("post_rst_log",   32'(log_o),   32'h20);

        // In-flight result dropped by a mid-stream reset.
        number_i = 32'hFFFF_FFFF;
        tick();
        valid_i = 1'b0;
        rst     = 1'b1;
        tick();
        check("midrst_valid", 32'(valid_o), 32'd0);
        check("midrst_log",   32'(log_o),   32'd0);
        rst = 1'b0;
        tick();
        check("midrst_idle_valid", 32'(valid_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
